// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the pipelined CPU: opcode encodings,
// field widths, the HALT instruction word and the prog_mem state type.
package cpu_isa_pkg;

    localparam int OPC_W = 5;
    localparam int OPR_W = 4;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_XOR  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b01001;
    localparam logic [OPC_W-1:0] OPC_ST   = 5'b01010;
    localparam logic [OPC_W-1:0] OPC_JMP  = 5'b10000;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 5'b10001;
    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b11010;

    localparam logic [OPC_W+OPR_W-1:0] HALT_WORD = {OPC_HALT, {OPR_W{1'b0}}};

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } pm_state_e;

endpackage

// File: rtl/prog_mem_ram.sv
// Single-port instruction array: synchronous write, synchronous read,
// no reset on the storage or the read register.
module prog_mem_ram #(
    parameter int W     = 9,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/prog_mem.sv
// Loadable instruction memory: sequential loader in LOAD, valid/ready
// fetch with one-cycle registered response in RUN.
module prog_mem
    import cpu_isa_pkg::*;
#(
    parameter int                 INSTR_W   = 9,
    parameter int                 PC_W      = 16,
    parameter int                 DEPTH     = 256,
    parameter logic [INSTR_W-1:0] HALT_WORD = cpu_isa_pkg::HALT_WORD,
    localparam int                LW        = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_done,
    output logic               load_err,
    output logic [LW-1:0]      prog_len,
    output logic               running,
    input  logic               fetch_valid,
    input  logic [PC_W-1:0]    fetch_pc,
    output logic               fetch_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_oor,
    input  logic               instr_ready
);

    localparam int AW = LW - 1;

    pm_state_e          state_q, state_d;
    logic               in_load;
    logic               full;
    logic               wr;
    logic               accept;
    logic               in_range;
    logic               hit_q;
    logic [AW-1:0]      ram_addr;
    logic [INSTR_W-1:0] ram_rdata;

    assign in_load     = (state_q == ST_LOAD);
    assign running     = (state_q == ST_RUN);
    assign full        = (prog_len == LW'(DEPTH));
    assign wr          = in_load && load_valid && !load_start && !full;
    assign fetch_ready = running && (!instr_valid || instr_ready);
    assign accept      = fetch_valid && fetch_ready;
    // Full-width compare so PCs at or beyond DEPTH never alias into the array
    assign in_range    = {1'b0, fetch_pc} < (PC_W + 1)'(prog_len);
    assign ram_addr    = in_load ? prog_len[AW-1:0] : fetch_pc[AW-1:0];
    assign instr       = hit_q ? ram_rdata : HALT_WORD;

    prog_mem_ram #(
        .W     (INSTR_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr),
        .re    (accept && in_range),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        if (load_start)
            state_d = ST_LOAD;
        else if (in_load && load_done)
            state_d = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            prog_len <= '0;
            load_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_start) begin
                prog_len <= '0;
                load_err <= 1'b0;
            end else if (wr) begin
                prog_len <= prog_len + 1'b1;
            end else if (in_load && load_valid && full) begin
                load_err <= 1'b1;
            end
        end
    end

    // Response register; a load_start drops any pending response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            hit_q       <= 1'b0;
            instr_oor   <= 1'b0;
        end else if (load_start) begin
            instr_valid <= 1'b0;
        end else if (accept) begin
            instr_valid <= 1'b1;
            hit_q       <= in_range;
            instr_oor   <= !in_range;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Randomised scoreboard bench for prog_mem (DEPTH = 8) with a
// behavioural memory model and directed boundary checks.
module tb_prog_mem;

    localparam int          IW   = 9;
    localparam int          PW   = 16;
    localparam int          D    = 8;
    localparam int          LW   = 4;
    localparam logic [IW-1:0] HALT = 9'h1A0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [IW-1:0] load_data = '0;
    logic          load_done = 1'b0;
    logic          load_err;
    logic [LW-1:0] prog_len;
    logic          running;
    logic          fetch_valid = 1'b0;
    logic [PW-1:0] fetch_pc = '0;
    logic          fetch_ready;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic          instr_oor;
    logic          instr_ready = 1'b0;

    always #5 clk = ~clk;

    prog_mem #(
        .INSTR_W (IW),
        .PC_W    (PW),
        .DEPTH   (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_done   (load_done),
        .load_err    (load_err),
        .prog_len    (prog_len),
        .running     (running),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_oor   (instr_oor),
        .instr_ready (instr_ready)
    );

    typedef struct {
        logic [IW-1:0] w;
        logic          oor;
    } exp_t;

    exp_t          q[$];
    logic [IW-1:0] ref_mem [D];
    int            ref_len = 0;
    bit            ref_run = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit ls, input bit lv, input bit ld,
                        input logic [IW-1:0] d, input bit fv,
                        input logic [PW-1:0] pc, input bit ir);
        exp_t e;
        @(negedge clk);
        load_start  = ls;
        load_valid  = lv;
        load_done   = ld;
        load_data   = d;
        fetch_valid = fv;
        fetch_pc    = pc;
        instr_ready = ir;
        #1;
        if (!ref_run) check("fetch_ready_in_load", fetch_ready, 0);
        if (ls) begin
            ref_len = 0;
            ref_run = 0;
            q.delete();
        end else begin
            if (fv && fetch_ready) begin
                if (int'(pc) < ref_len) begin
                    e.w = ref_mem[int'(pc)];
                    e.oor = 1'b0;
                end else begin
                    e.w = HALT;
                    e.oor = 1'b1;
                end
                q.push_back(e);
            end
            if (!ref_run) begin
                if (lv && ref_len < D) begin
                    ref_mem[ref_len] = d;
                    ref_len++;
                end
                if (ld) ref_run = 1;
            end
        end
    endtask

    task automatic idle(input bit ir);
        step(0, 0, 0, '0, 0, '0, ir);
    endtask

    task automatic load(input logic [IW-1:0] d);
        step(0, 1, 0, d, 0, '0, 1);
    endtask

    task automatic fetch(input logic [PW-1:0] pc);
        step(0, 0, 0, '0, 1, pc, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        idle(1);
        check("drain_queue_empty", q.size(), 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a response is consumed when instr_valid && instr_ready
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && instr_valid && instr_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_response: got %0h, want none",
                             instr);
                end else begin
                    e = q.pop_front();
                    check("instr", instr, e.w);
                    check("instr_oor", instr_oor, e.oor);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [IW-1:0] words [4];
        words[0] = 9'h061;
        words[1] = 9'h120;
        words[2] = 9'h191;
        words[3] = 9'h164;

        #12;
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, HALT);
        check("rst_instr_oor", instr_oor, 0);
        check("rst_prog_len", prog_len, 0);
        check("rst_load_err", load_err, 0);
        check("rst_running", running, 0);
        check("rst_fetch_ready", fetch_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 4-word load and back-to-back fetch
        step(1, 0, 0, '0, 0, '0, 0);
        for (int i = 0; i < 3; i++) load(words[i]);
        step(0, 1, 1, words[3], 0, '0, 1);
        after_edge();
        check("running_after_done", running, 1);
        check("prog_len_4", prog_len, 4);
        for (int i = 0; i < 4; i++) begin
            fetch(PW'(i));
            check("b2b_fetch_ready", fetch_ready, 1);
        end
        fetch(16'd4);
        fetch(16'hFFFF);
        fetch(16'd8);
        fetch(16'd12);
        drain();

        // Backpressure
        step(0, 0, 0, '0, 1, 16'd1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0, 1, 16'd2, 0);
            check("bp_fetch_ready", fetch_ready, 0);
            check("bp_instr_valid", instr_valid, 1);
            check("bp_instr_stable", instr, words[1]);
        end
        drain();

        // load_valid with load_done in the same cycle
        step(1, 0, 0, '0, 0, '0, 0);
        load(9'h0A5);
        load(9'h15A);
        step(0, 1, 1, 9'h033, 0, '0, 1);
        after_edge();
        check("same_cycle_running", running, 1);
        check("same_cycle_prog_len", prog_len, 3);
        for (int i = 0; i < 4; i++) fetch(PW'(i));
        drain();

        // load_start drops a pending response
        step(0, 0, 0, '0, 1, 16'd0, 0);
        step(1, 0, 0, '0, 0, '0, 0);
        after_edge();
        check("ls_instr_valid", instr_valid, 0);
        check("ls_running", running, 0);
        check("ls_prog_len", prog_len, 0);

        // Overflow with 9 beats
        for (int i = 0; i < 9; i++) begin
            load(IW'($urandom));
            if (i == 7) begin
                after_edge();
                check("full_prog_len", prog_len, 8);
                check("full_no_err", load_err, 0);
            end
        end
        after_edge();
        check("ovf_prog_len", prog_len, 8);
        check("ovf_load_err", load_err, 1);
        step(0, 0, 1, '0, 0, '0, 1);
        for (int i = 0; i < 10; i++) fetch(PW'(i));
        fetch(16'hFFFF);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [PW-1:0] pc;
            pc = ($urandom_range(0, 3) == 0) ? PW'($urandom)
                                             : PW'($urandom_range(0, 11));
            step(0, 0, 0, '0, 1'($urandom), pc,
                 $urandom_range(0, 3) != 0);
        end
        drain();

        // Asynchronous reset mid-load
        step(1, 0, 0, '0, 0, '0, 0);
        load(9'h011);
        load(9'h022);
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        check("pre_rst_prog_len", prog_len, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_prog_len", prog_len, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_instr_valid", instr_valid, 0);
        check("mid_rst_instr", instr, HALT);
        check("mid_rst_instr_oor", instr_oor, 0);
        check("mid_rst_load_err", load_err, 0);
        check("mid_rst_fetch_ready", fetch_ready, 0);
        ref_len = 0;
        ref_run = 0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        load(9'h1F0);
        load(9'h00F);
        step(0, 1, 1, 9'h0C3, 0, '0, 1);
        for (int i = 0; i < 200; i++) begin
            step(0, 0, 0, '0, 1'($urandom),
                 PW'($urandom_range(0, 9)), $urandom_range(0, 2) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
